vga_output_stage: RTL and testbench
===================================

# vga_output_stage

Final stage of the video path, downstream of the horizontal/vertical timing counters and the pixel renderer. It delays the timing-derived sync/blank/position signals by a fixed number of pixel-enable cycles to match renderer latency. It then blanks, optionally Bayer-dithers 4-bit RGB down to 2-bit RGB, and registers the result onto the 8-bit VGA PMOD bus. It also supplies a frame-start strobe and a frame counter to the animation logic.

## Interface
- `PIPE_DEPTH`, 2: renderer latency in enabled cycles; timing signals are delayed by this much; legal range 1..8.
- `SYNC_IDLE`, 1'b1: inactive level of both sync inputs, already polarity-applied upstream; also the reset fill value.
- `FRAME_BITS`, 8: width of `frame_count`.
- `clk` in 1: pixel-domain clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: pixel enable, same strobe that advances the timing counters.
- `hsync_in` in 1: horizontal sync from the timing stage.
- `vsync_in` in 1: vertical sync from the timing stage.
- `blank_in` in 1: OR of horizontal and vertical blank.
- `x_lsb` in 2: counter[1:0] of the horizontal timing stage.
- `y_lsb` in 2: counter[1:0] of the vertical timing stage.
- `r_in`, `g_in`, `b_in` in 4 each: renderer colour, valid `PIPE_DEPTH` enabled cycles after the matching timing inputs.
- `dither_en` in 1: 1 = ordered dither, 0 = truncate.
- `vga_out` out 8: {hsync, B[0], G[0], R[0], vsync, B[1], G[1], R[1]}.
- `frame_start` out 1: one-cycle pulse at the start of each frame.
- `frame_count` out `FRAME_BITS`: frames since reset.

## Operation
- Delay line: `PIPE_DEPTH` registers, each holding {hsync, vsync, blank, x_lsb, y_lsb}.
  - Shifts only when `enable`=1; holds otherwise.
  - Reset fill: sync=`SYNC_IDLE`, blank=1, x/y=0.
- Tail of the delay line (`d_*`) is aligned with `r_in`/`g_in`/`b_in`.
- Bayer threshold: t = M[d_y][d_x], with rows {0,8,2,10}, {12,4,14,6}, {3,11,1,9}, {15,7,13,5}.
- Per channel c (4 bits):
  - `dither_en`=1: s = c + t[3:2] (5 bits); q = s[4] ? 2'b11 : s[3:2]. Saturates, never wraps.
  - `dither_en`=0: q = c[3:2].
- If `d_blank`=1, all q = 0 regardless of colour input.
- Output register loads {d_hsync, qB[0], qG[0], qR[0], d_vsync, qB[1], qG[1], qR[1]} on enabled cycles; holds otherwise.
- Frame detect: a registered copy of `d_vsync` (`vs_prev`) updates on enabled cycles.
  - When `enable`=1, `vs_prev`==`SYNC_IDLE` and `d_vsync`!=`SYNC_IDLE`: `frame_start`=1 for that one clock and `frame_count` increments.
  - `frame_count` wraps from all-ones to 0.
- `dither_en` is sampled combinationally at the output stage; a change takes effect on the next enabled load with no glitch handling.

## Timing
- Latency from timing inputs to `vga_out` sync bits: `PIPE_DEPTH`+1 enabled cycles.
- Latency from colour inputs to `vga_out`: 1 enabled cycle.
- Reset values:
  - `vga_out` = {`SYNC_IDLE`,3'b0,`SYNC_IDLE`,3'b0}.
  - `frame_start`=0, `frame_count`=0, `vs_prev`=`SYNC_IDLE`.
- `frame_start` is registered and asserts on the same clock edge on which `vga_out` shows vsync going active.
- `enable` low: no state changes anywhere; `frame_start` drops to 0 after one clock.
- Reset mid-frame: everything returns to reset values immediately, asynchronously. The first frame after release is counted only on a true idle→active vsync edge.

## Structure
- Shared video package: Bayer matrix constant, PMOD bit-index constants, RGB222/RGB444 typedefs.
- One natural sub-module: `sync_delay_line`, a parameterised enable-gated shift register with a reset fill value.

## Test plan
- Reset with `PIPE_DEPTH`=2, no `enable` → `vga_out`=8'h88, `frame_count`=0, `frame_start`=0.
- Toggle `hsync_in` 1→0 with `enable`=1 every cycle → `vga_out[7]` falls exactly 3 clocks later; with `enable` every 4th clock → 12 clocks later.
- `blank_in`=0, colour 4'hF, `dither_en`=1 → all colour bits 1 for every x/y; `blank_in`=1 → colour bits 0.
- Colour 4'h6, `dither_en`=1, sweep x/y over 4×4:
  - t[3:2]∈{0,1} → q=2'b01.
  - t[3:2]∈{2,3} → q=2'b10.
  - Expect eight of each across the 16 positions.
- Drive 256 vsync pulses → 256 `frame_start` pulses, `frame_count` wraps to 0; holding vsync active across many cycles gives only one pulse.
- Assert `reset_n` low mid-line → `vga_out`=8'h88 within the same cycle, and the delay line refills to idle.

Source files
------------

// File: rtl/vga_output_stage_pkg.sv
// Shared video definitions: Bayer matrix, PMOD bit positions, colour types.
// Also holds the per-channel dither helper used by the output stage.
package vga_output_stage_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb222_t;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       blank;
    logic [1:0] x;
    logic [1:0] y;
  } timing_t;

  // PMOD pin order: {hsync, B0, G0, R0, vsync, B1, G1, R1}
  localparam int PMOD_HS = 7;
  localparam int PMOD_B0 = 6;
  localparam int PMOD_G0 = 5;
  localparam int PMOD_R0 = 4;
  localparam int PMOD_VS = 3;
  localparam int PMOD_B1 = 2;
  localparam int PMOD_G1 = 1;
  localparam int PMOD_R1 = 0;

  // 4x4 ordered-dither matrix, row-major (row = y, column = x), first entry in MSBs
  localparam logic [63:0] BAYER_M = {
    4'd0,  4'd8,  4'd2,  4'd10,
    4'd12, 4'd4,  4'd14, 4'd6,
    4'd3,  4'd11, 4'd1,  4'd9,
    4'd15, 4'd7,  4'd13, 4'd5
  };

  function automatic logic [3:0] bayer_thr(input logic [1:0] x, input logic [1:0] y);
    logic [3:0] idx;
    idx = {y, x};
    return BAYER_M[(15 - int'(idx)) * 4 +: 4];
  endfunction

  // Adds the top two threshold bits and saturates instead of wrapping to black.
  function automatic logic [1:0] dither_chan(input logic [3:0] c, input logic [3:0] thr,
                                             input logic en);
    logic [4:0] s;
    s = {1'b0, c} + {3'b000, thr[3:2]};
    if (!en) return c[3:2];
    return s[4] ? 2'b11 : s[3:2];
  endfunction

endpackage

// File: rtl/vga_output_stage_if.sv
// Timing/colour inputs and PMOD/frame outputs of the VGA output stage.
// Master drives the video inputs; slave is the output stage itself.
interface vga_output_stage_if #(
  parameter int FRAME_BITS = 8
);
  logic                  enable;
  logic                  hsync_in;
  logic                  vsync_in;
  logic                  blank_in;
  logic [1:0]            x_lsb;
  logic [1:0]            y_lsb;
  logic [3:0]            r_in;
  logic [3:0]            g_in;
  logic [3:0]            b_in;
  logic                  dither_en;
  logic [7:0]            vga_out;
  logic                  frame_start;
  logic [FRAME_BITS-1:0] frame_count;

  modport master (
    output enable, hsync_in, vsync_in, blank_in, x_lsb, y_lsb,
    output r_in, g_in, b_in, dither_en,
    input  vga_out, frame_start, frame_count
  );

  modport slave (
    input  enable, hsync_in, vsync_in, blank_in, x_lsb, y_lsb,
    input  r_in, g_in, b_in, dither_en,
    output vga_out, frame_start, frame_count
  );
endinterface

// File: rtl/vga_output_stage_sync_delay_line.sv
// Enable-gated shift register that refills with FILL on reset.
// Latency DEPTH enabled cycles; holds contents while shift is low.
module sync_delay_line #(
  parameter int               WIDTH = 7,
  parameter int               DEPTH = 2,
  parameter logic [WIDTH-1:0] FILL  = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] tail
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= FILL;
    end else if (shift) begin
      stage[0] <= data;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tail = stage[DEPTH-1];

endmodule

// File: rtl/vga_output_stage.sv
// Aligns timing to renderer latency, blanks/dithers RGB444 to RGB222, drives PMOD.
// Sync latency PIPE_DEPTH+1 enabled cycles, colour 1; no backpressure, enable-gated.
module vga_output_stage
  import vga_output_stage_pkg::*;
#(
  parameter int   PIPE_DEPTH = 2,
  parameter logic SYNC_IDLE  = 1'b1,
  parameter int   FRAME_BITS = 8
) (
  input logic               clk,
  input logic               reset_n,
  vga_output_stage_if.slave vid
);

  localparam timing_t TIMING_FILL = '{
    hsync: SYNC_IDLE, vsync: SYNC_IDLE, blank: 1'b1, x: 2'd0, y: 2'd0
  };
  localparam logic [7:0] VGA_IDLE = {SYNC_IDLE, 3'b000, SYNC_IDLE, 3'b000};

  timing_t               tim_head;
  timing_t               tim_tail;
  rgb444_t               colour;
  rgb222_t               q;
  logic [3:0]            thr;
  logic [7:0]            vga_next;
  logic [7:0]            vga_reg;
  logic                  vs_prev;
  logic                  frame_edge;
  logic                  frame_start_reg;
  logic [FRAME_BITS-1:0] frame_cnt;

  assign tim_head = '{
    hsync: vid.hsync_in, vsync: vid.vsync_in, blank: vid.blank_in,
    x: vid.x_lsb, y: vid.y_lsb
  };
  assign colour = '{r: vid.r_in, g: vid.g_in, b: vid.b_in};

  sync_delay_line #(
    .WIDTH ($bits(timing_t)),
    .DEPTH (PIPE_DEPTH),
    .FILL  (TIMING_FILL)
  ) u_sync_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .shift   (vid.enable),
    .data    (tim_head),
    .tail    (tim_tail)
  );

  always_comb begin
    thr = bayer_thr(tim_tail.x, tim_tail.y);
    q.r = dither_chan(colour.r, thr, vid.dither_en);
    q.g = dither_chan(colour.g, thr, vid.dither_en);
    q.b = dither_chan(colour.b, thr, vid.dither_en);
    if (tim_tail.blank) q = '0;

    vga_next          = '0;
    vga_next[PMOD_HS] = tim_tail.hsync;
    vga_next[PMOD_B0] = q.b[0];
    vga_next[PMOD_G0] = q.g[0];
    vga_next[PMOD_R0] = q.r[0];
    vga_next[PMOD_VS] = tim_tail.vsync;
    vga_next[PMOD_B1] = q.b[1];
    vga_next[PMOD_G1] = q.g[1];
    vga_next[PMOD_R1] = q.r[1];
  end

  // vs_prev tracks what vga_out shows, so frame_start lines up with the visible vsync edge
  assign frame_edge = (vs_prev == SYNC_IDLE) && (tim_tail.vsync != SYNC_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_reg         <= VGA_IDLE;
      vs_prev         <= SYNC_IDLE;
      frame_start_reg <= 1'b0;
      frame_cnt       <= '0;
    end else begin
      frame_start_reg <= vid.enable && frame_edge;
      if (vid.enable) begin
        vga_reg <= vga_next;
        vs_prev <= tim_tail.vsync;
        if (frame_edge) frame_cnt <= frame_cnt + FRAME_BITS'(1);
      end
    end
  end

  assign vid.vga_out     = vga_reg;
  assign vid.frame_start = frame_start_reg;
  assign vid.frame_count = frame_cnt;

endmodule

// File: tb/tb_vga_output_stage.sv
// Directed bench for vga_output_stage: queue-based reference model checked every cycle,
// plus literal expectations for latency, dither counts, frame counting and async reset.
module tb_vga_output_stage;

  localparam int   PD   = 2;
  localparam logic IDLE = 1'b1;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  vga_output_stage_if #(.FRAME_BITS(8)) vid ();

  vga_output_stage #(
    .PIPE_DEPTH (PD),
    .SYNC_IDLE  (IDLE),
    .FRAME_BITS (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .vid     (vid)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit hs;
    bit vs;
    bit bl;
    int x;
    int y;
  } tim_t;

  tim_t     mq[$];
  tim_t     md;
  tim_t     mn;
  bit [7:0] exp_vga;
  bit       exp_fs;
  int       exp_fc;
  bit       m_vs_prev;
  int       mt, qr, qg, qb;
  int       bay [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

  function automatic int qlev(input int c, input int t, input bit en);
    int s;
    if (!en) return c / 4;
    s = c + t / 4;
    return (s > 15) ? 3 : s / 4;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      mn.hs = IDLE; mn.vs = IDLE; mn.bl = 1'b1; mn.x = 0; mn.y = 0;
      for (int i = 0; i < PD; i++) mq.push_back(mn);
      exp_vga   = 8'h88;
      exp_fs    = 1'b0;
      exp_fc    = 0;
      m_vs_prev = IDLE;
    end else if (vid.enable) begin
      md = mq.pop_front();
      mn.hs = vid.hsync_in; mn.vs = vid.vsync_in; mn.bl = vid.blank_in;
      mn.x = int'(vid.x_lsb); mn.y = int'(vid.y_lsb);
      mq.push_back(mn);
      mt = bay[md.y][md.x];
      qr = md.bl ? 0 : qlev(int'(vid.r_in), mt, vid.dither_en);
      qg = md.bl ? 0 : qlev(int'(vid.g_in), mt, vid.dither_en);
      qb = md.bl ? 0 : qlev(int'(vid.b_in), mt, vid.dither_en);
      exp_vga = {md.hs, qb[0], qg[0], qr[0], md.vs, qb[1], qg[1], qr[1]};
      exp_fs  = (m_vs_prev == IDLE) && (md.vs != IDLE);
      if (exp_fs) exp_fc = (exp_fc + 1) % 256;
      m_vs_prev = md.vs;
    end else begin
      exp_fs = 1'b0;
    end
  end

  bit cmp_on = 1'b0;
  int fs_seen = 0;

  always @(negedge clk) begin
    if (cmp_on) begin
      check("model_vga_out", vid.vga_out, exp_vga);
      check("model_frame_start", vid.frame_start, exp_fs);
      check("model_frame_count", vid.frame_count, exp_fc);
    end
    if (vid.frame_start) fs_seen++;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int n01, n10, rq;

  initial begin
    vid.enable = 1'b0; vid.hsync_in = IDLE; vid.vsync_in = IDLE; vid.blank_in = 1'b1;
    vid.x_lsb = 2'd0; vid.y_lsb = 2'd0; vid.r_in = 4'd0; vid.g_in = 4'd0; vid.b_in = 4'd0;
    vid.dither_en = 1'b0;

    #1 reset_n = 1'b0;
    tick(3);
    check("reset_vga_out", vid.vga_out, 8'h88);
    check("reset_frame_count", vid.frame_count, 8'd0);
    check("reset_frame_start", vid.frame_start, 1'b0);
    cmp_on  = 1'b1;
    reset_n = 1'b1;
    tick(2);
    check("idle_no_enable", vid.vga_out, 8'h88);

    // hsync latency, enable every cycle
    vid.enable = 1'b1;
    tick(4);
    vid.hsync_in = 1'b0;
    tick(2);
    check("hs_still_high_2clk", vid.vga_out[7], 1'b1);
    tick(1);
    check("hs_low_3clk", vid.vga_out[7], 1'b0);
    vid.hsync_in = 1'b1;
    tick(4);

    // hsync latency, enable every 4th clock
    vid.hsync_in = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      vid.enable = (k % 4 == 0);
      tick(1);
      if (k == 11) check("hs_sparse_high_11clk", vid.vga_out[7], 1'b1);
      if (k == 12) check("hs_sparse_low_12clk", vid.vga_out[7], 1'b0);
    end
    vid.enable = 1'b1;
    vid.hsync_in = 1'b1;
    tick(4);

    // full-scale colour saturates at every matrix position
    vid.blank_in = 1'b0; vid.dither_en = 1'b1;
    vid.r_in = 4'hF; vid.g_in = 4'hF; vid.b_in = 4'hF;
    for (int p = 0; p < 16; p++) begin
      vid.x_lsb = 2'(p % 4); vid.y_lsb = 2'(p / 4);
      tick(3);
      check("colour_F_all_ones", {vid.vga_out[6:4], vid.vga_out[2:0]}, 6'h3F);
    end
    vid.blank_in = 1'b1;
    tick(3);
    check("blank_zero_colour", {vid.vga_out[6:4], vid.vga_out[2:0]}, 6'h00);

    // mid-grey sweep: half the thresholds round up
    vid.blank_in = 1'b0;
    vid.r_in = 4'h6; vid.g_in = 4'h6; vid.b_in = 4'h6;
    n01 = 0; n10 = 0;
    for (int p = 0; p < 16; p++) begin
      vid.x_lsb = 2'(p % 4); vid.y_lsb = 2'(p / 4);
      tick(3);
      rq = int'({vid.vga_out[0], vid.vga_out[4]});
      if (rq == 1) n01++;
      if (rq == 2) n10++;
      if (p == 0) check("grey_x0y0_t0", rq, 1);
      if (p == 1) check("grey_x1y0_t8", rq, 2);
    end
    check("grey_count_01", n01, 8);
    check("grey_count_10", n10, 8);

    // mixed directed patterns, truncate then dither, with enable gaps and vsync pulses
    for (int i = 0; i < 48; i++) begin
      vid.dither_en = (i >= 24);
      vid.r_in = 4'(i % 16);
      vid.g_in = 4'((i * 7) % 16);
      vid.b_in = 4'(15 - (i % 16));
      vid.x_lsb = 2'(i % 4);
      vid.y_lsb = 2'((i / 3) % 4);
      vid.blank_in = (i % 7 == 3);
      vid.hsync_in = (i % 9 < 2) ? 1'b0 : 1'b1;
      vid.vsync_in = (i % 11 < 2) ? 1'b0 : 1'b1;
      vid.enable = (i % 5 != 4);
      tick(1);
    end
    vid.enable = 1'b1; vid.vsync_in = IDLE; vid.hsync_in = IDLE;
    tick(4);

    // 256 frames wrap the counter
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(3);
    fs_seen = 0;
    for (int n = 0; n < 256; n++) begin
      vid.vsync_in = 1'b0;
      tick(1);
      vid.vsync_in = 1'b1;
      tick(1);
    end
    tick(4);
    check("frame_pulses_256", fs_seen, 256);
    check("frame_count_wrap", vid.frame_count, 8'd0);
    fs_seen = 0;
    vid.vsync_in = 1'b0;
    tick(20);
    vid.vsync_in = 1'b1;
    tick(4);
    check("long_vsync_one_pulse", fs_seen, 1);
    check("long_vsync_count", vid.frame_count, 8'd1);

    // asynchronous reset mid-line
    vid.hsync_in = 1'b0; vid.vsync_in = 1'b1; vid.blank_in = 1'b0; vid.dither_en = 1'b1;
    vid.r_in = 4'hF; vid.g_in = 4'hF; vid.b_in = 4'hF;
    tick(4);
    check("midline_active", vid.vga_out, 8'h7F);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_vga", vid.vga_out, 8'h88);
    check("async_reset_count", vid.frame_count, 8'd0);
    tick(1);
    reset_n = 1'b1;
    tick(1);
    check("refill_1", vid.vga_out, 8'h88);
    tick(1);
    check("refill_2", vid.vga_out, 8'h88);
    tick(1);
    check("refill_3_live", vid.vga_out, 8'h7F);

    cmp_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
